rf_wb_arbiter: RTL

- Owns the single write port (WE/A3/WD3) of the 32x32 register file.
- Shares that port between two writeback requesters: req0 (ALU writeback) and req1 (load/multi-cycle unit), using valid/ready handshakes and round-robin arbitration.
- Registers the winning write and drives the regfile write port one cycle later.
- Keeps a 32-bit pending-write scoreboard so the issue logic can detect RAW hazards.

---
 rtl/rf_wb_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register-file write port: round-robin between ALU and load unit,
// registered write stage, and a pending-write scoreboard. Optional bypass: RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [4:0]      req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4:0]      req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd3,
`ifdef RF_WB_BYPASS_EN
  input  logic [4:0]      byp_a1,
  input  logic [4:0]      byp_a2,
  output logic            byp_hit1,
  output logic            byp_hit2,
  output logic [XLEN-1:0] byp_data,
`endif
  output logic [NREG-1:0] busy
);

  logic            r_rr_last;  // index of the last nonzero grant
  logic            r_rf_we;
  logic [4:0]      r_rf_a3;
  logic [XLEN-1:0] r_rf_wd3;
  logic [NREG-1:0] r_busy;

  logic            w_nz0, w_nz1, w_gnt0, w_gnt1, w_acc;
  logic [4:0]      w_acc_rd;
  logic [XLEN-1:0] w_acc_data;
  logic            w_clr_en;
  logic [4:0]      w_clr_rd;
  logic [NREG-1:0] w_set, w_clr, w_busy_d;

  always_comb begin
    w_nz0 = req0_valid && (req0_rd != 5'd0);
    w_nz1 = req1_valid && (req1_rd != 5'd0);
    w_gnt0 = w_nz0 && (!w_nz1 || r_rr_last);
    w_gnt1 = w_nz1 && (!w_nz0 || !r_rr_last);
    // x0 writes are sunk immediately without consuming a grant
    req0_ready = (req0_valid && (req0_rd == 5'd0)) || w_gnt0;
    req1_ready = (req1_valid && (req1_rd == 5'd0)) || w_gnt1;
    w_acc      = w_gnt0 || w_gnt1;
    w_acc_rd   = w_gnt0 ? req0_rd : req1_rd;
    w_acc_data = w_gnt0 ? req0_data : req1_data;
  end

`ifdef RF_WB_BYPASS_EN
  assign w_clr_en = w_acc;
  assign w_clr_rd = w_acc_rd;
  assign byp_hit1 = r_rf_we && (r_rf_a3 != 5'd0) && (r_rf_a3 == byp_a1);
  assign byp_hit2 = r_rf_we && (r_rf_a3 != 5'd0) && (r_rf_a3 == byp_a2);
  assign byp_data = r_rf_wd3;
`else
  assign w_clr_en = r_rf_we;
  assign w_clr_rd = r_rf_a3;
`endif

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (iss_valid && (iss_rd != 5'd0)) w_set[iss_rd] = 1'b1;
    if (w_clr_en && (w_clr_rd != 5'd0)) w_clr[w_clr_rd] = 1'b1;
    // set after clear so a newer producer keeps the bit
    w_busy_d    = (r_busy & ~w_clr) | w_set;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= 1'b1;
      r_rf_we   <= 1'b0;
      r_rf_a3   <= 5'd0;
      r_rf_wd3  <= '0;
      r_busy    <= '0;
    end else begin
      r_rf_we <= w_acc;
      if (w_acc) begin
        r_rf_a3   <= w_acc_rd;
        r_rf_wd3  <= w_acc_data;
        r_rr_last <= w_gnt1;
      end
      r_busy <= w_busy_d;
    end
  end

  assign rf_we  = r_rf_we;
  assign rf_a3  = r_rf_a3;
  assign rf_wd3 = r_rf_wd3;
  assign busy   = r_busy;

endmodule
